fmsynth_sched: RTL and testbench

Timed register-write scheduler that sits between the CPU bus and the `fmsynth` register port. The CPU queues (delay, address, data) entries, and the block replays them to `fmsynth` at tick-accurate intervals, so note-on/note-off sequences play without CPU babysitting. A direct pass-through port gives the CPU immediate register access, arbitrated against the queue.

---
 rtl/fmsynth_sched_pkg.sv | 9 +
 rtl/sched_fifo.sv | 44 ++++
 rtl/fmsynth_sched.sv | 91 +++++++++
 tb/tb_fmsynth_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmsynth_sched_pkg.sv
// fmsynth_sched_pkg: scheduler state encoding and the 56-bit queued register-write entry
package fmsynth_sched_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
  typedef struct packed {
    logic [15:0] delay;
    logic [7:0]  addr;
    logic [31:0] data;
  } entry_t;
endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: FWFT entry FIFO (push/pop/flush in; head/level/full/empty/sticky ovf out)
module sched_fifo import fmsynth_sched_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  entry_t                   din_i,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  entry_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q;
  logic ovf_q, do_push, do_pop;
  assign full_o  = lvl_q == LW'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;
  assign ovf_o   = ovf_q;
  assign head_o  = mem_q[rp_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk)
    if (do_push && !flush_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk or posedge reset)
    if (reset || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
      if (push_i && !do_push) ovf_q <= 1'b1;
    end
endmodule

// File: rtl/fmsynth_sched.sv
// fmsynth_sched: tick-timed replay of queued (delay,addr,data) writes to fmsynth, muxed with a direct CPU port
module fmsynth_sched import fmsynth_sched_pkg::*; #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             d_addr,
  input  logic [31:0]            d_wrdata,
  input  logic                   d_wren,
  output logic [31:0]            d_rddata,
  output logic                   d_wait,
  input  logic                   q_push,
  input  logic [15:0]            q_delay,
  input  logic [7:0]             q_addr,
  input  logic [31:0]            q_data,
  input  logic                   q_flush,
  input  logic                   sched_en,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   q_full,
  output logic                   q_ovf,
  output logic                   busy,
  output logic [7:0]             fm_addr,
  output logic [31:0]            fm_wrdata,
  output logic                   fm_wren,
  input  logic [31:0]            fm_rddata,
  input  logic                   fm_wait
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t state_q;
  logic [15:0] cnt_q;
  logic [7:0] cur_addr_q;
  logic [31:0] cur_data_q;
  logic [TW-1:0] tdiv_q;
  logic kill_q, tick, empty, pop, iss;
  entry_t q_entry, head, head_eff;
  assign q_entry  = '{delay: q_delay, addr: q_addr, data: q_data};
  assign head_eff = empty ? q_entry : head;
  assign tick     = tdiv_q == TW'(TICK_DIV - 1);
  assign iss      = state_q == ISSUE;
  assign pop      = iss && !fm_wait && !kill_q;
  assign busy     = state_q != IDLE;
  assign fm_wren   = iss || d_wren;
  assign fm_addr   = iss ? cur_addr_q : d_addr;
  assign fm_wrdata = iss ? cur_data_q : d_wrdata;
  assign d_wait    = iss || fm_wait;
  assign d_rddata  = fm_rddata;
  sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (q_push),
    .pop_i   (pop),
    .flush_i (q_flush),
    .din_i   (q_entry),
    .head_o  (head),
    .level_o (q_level),
    .full_o  (q_full),
    .empty_o (empty),
    .ovf_o   (q_ovf)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) tdiv_q <= '0;
    else tdiv_q <= tick ? '0 : tdiv_q + TW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_addr_q <= '0;
      cur_data_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sched_en && !q_flush && (!empty || q_push)) begin
          state_q    <= WAIT;
          cnt_q      <= head_eff.delay;
          cur_addr_q <= head_eff.addr;
          cur_data_q <= head_eff.data;
        end
        WAIT: if (q_flush) state_q <= IDLE;
          else if (cnt_q == '0 && sched_en && !d_wren) begin
            state_q <= ISSUE;
            kill_q  <= 1'b0;
          end else if (tick && sched_en && cnt_q != '0) cnt_q <= cnt_q - 16'd1;
        ISSUE: begin
          if (q_flush) kill_q <= 1'b1;
          if (!fm_wait) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fmsynth_sched.sv
// tb_fmsynth_sched: scoreboard bench with directed timing cases and randomized traffic for fmsynth_sched
module tb_fmsynth_sched;
  localparam int DEPTH = 4;
  localparam int TD = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] d_addr, q_addr, fm_addr;
  logic [31:0] d_wrdata, d_rddata, q_data, fm_wrdata, fm_rddata;
  logic d_wren, d_wait, q_push, q_flush, sched_en, q_full, q_ovf, busy, fm_wren, fm_wait;
  logic [15:0] q_delay;
  logic [$clog2(DEPTH):0] q_level;
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t qsb[$], dsb[$];
  wr_t mon_e, drv_e;
  int iss_cyc[$];
  int cyc, n_cmp, n_bad, last_d_cyc, qwren, n0, e1, e2, xc, good;
  logic dn, m_ovf;
  always #5 clk = ~clk;
  fmsynth_sched #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .d_addr(d_addr), .d_wrdata(d_wrdata), .d_wren(d_wren),
    .d_rddata(d_rddata), .d_wait(d_wait), .q_push(q_push), .q_delay(q_delay), .q_addr(q_addr),
    .q_data(q_data), .q_flush(q_flush), .sched_en(sched_en), .q_level(q_level), .q_full(q_full),
    .q_ovf(q_ovf), .busy(busy), .fm_addr(fm_addr), .fm_wrdata(fm_wrdata), .fm_wren(fm_wren),
    .fm_rddata(fm_rddata), .fm_wait(fm_wait)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic int exp_issue(input int w, input int d);
    int n = 0;
    if (d == 0) return w + 1;
    for (int c = w; c < w + 100000; c++)
      if (c % TD == TD - 1) begin
        n++;
        if (n == d) return c + 2;
      end
    return -1;
  endfunction
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
  always @(negedge clk)
    if (!reset) begin
      if (fm_wren && d_wait) qwren++;
      if (fm_wren && !fm_wait) begin
        if (d_wait) begin
          iss_cyc.push_back(cyc);
          if (qsb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL qwr_unexpected: got addr %h data %h expected none", fm_addr, fm_wrdata);
          end else begin
            mon_e = qsb.pop_front();
            chk("qwr_addr", 32'(fm_addr), 32'(mon_e.a));
            chk("qwr_data", fm_wrdata, mon_e.d);
          end
        end else begin
          last_d_cyc = cyc;
          if (dsb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dwr_unexpected: got addr %h data %h expected none", fm_addr, fm_wrdata);
          end else begin
            mon_e = dsb.pop_front();
            chk("dwr_addr", 32'(fm_addr), 32'(mon_e.a));
            chk("dwr_data", fm_wrdata, mon_e.d);
          end
        end
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic qpush(input logic [15:0] dl, input logic [7:0] a, input logic [31:0] d);
    q_push = 1'b1;
    q_delay = dl;
    q_addr = a;
    q_data = d;
    drv_e.a = a;
    drv_e.d = d;
    if (qsb.size() < DEPTH) qsb.push_back(drv_e);
    else m_ovf = 1'b1;
  endtask
  task automatic dstart(input logic [7:0] a, input logic [31:0] d);
    d_wren = 1'b1;
    d_addr = a;
    d_wrdata = d;
    drv_e.a = a;
    drv_e.d = d;
    dsb.push_back(drv_e);
  endtask
  task automatic drain(input string n);
    int k = 0;
    while (k < 300 && (qsb.size() != 0 || dsb.size() != 0 || busy || d_wren)) begin
      @(negedge clk);
      dn = d_wren && !d_wait;
      step();
      if (dn) d_wren = 1'b0;
      k++;
    end
    chk(n, 32'(k < 300), 32'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    d_addr = '0; d_wrdata = '0; d_wren = 0; q_push = 0; q_delay = '0; q_addr = '0; q_data = '0;
    q_flush = 0; sched_en = 1; fm_wait = 0; fm_rddata = 32'hA5A5_1234; m_ovf = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_level", 32'(q_level), 0);
    chk("rst_full", 32'(q_full), 0);
    chk("rst_ovf", 32'(q_ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fm_wren", 32'(fm_wren), 0);
    chk("rst_d_wait", 32'(d_wait), 0);
    chk("rst_rddata", d_rddata, 32'hA5A5_1234);
    step();
    n0 = cyc;
    qwren = 0;
    qpush(16'd0, 8'h60, 32'h0030212C);
    step();
    q_push = 0;
    @(negedge clk);
    chk("single_level", 32'(q_level), 1);
    chk("single_busy", 32'(busy), 1);
    step();
    drain("single_drain");
    chk("single_count", 32'(iss_cyc.size()), 1);
    chk("single_cycle", 32'(iss_cyc.size() > 0 ? iss_cyc[0] : -1), 32'(n0 + 2));
    chk("single_wren_cycles", 32'(qwren), 1);
    @(negedge clk);
    chk("single_level_after", 32'(q_level), 0);
    chk("single_busy_after", 32'(busy), 0);
    step();
    iss_cyc.delete();
    n0 = cyc;
    qpush(16'd3, 8'h80, 32'h1111_0080);
    step();
    qpush(16'd2, 8'h82, 32'h2222_0082);
    step();
    q_push = 0;
    drain("delay_drain");
    e1 = exp_issue(n0 + 1, 3);
    e2 = exp_issue(e1 + 2, 2);
    chk("delay_count", 32'(iss_cyc.size()), 2);
    chk("delay_first", 32'(iss_cyc.size() > 0 ? iss_cyc[0] : -1), 32'(e1));
    chk("delay_second", 32'(iss_cyc.size() > 1 ? iss_cyc[1] : -1), 32'(e2));
    iss_cyc.delete();
    n0 = cyc;
    good = 0;
    qpush(16'd0, 8'h44, 32'hDEAD_BEEF);
    step();
    q_push = 0;
    step();
    qwren = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) fm_wait = 1;
      if (i == 1) dstart(8'h21, 32'h0BAD_F00D);
      if (i == 5) fm_wait = 0;
      @(negedge clk);
      if (fm_wren && fm_addr == 8'h44 && fm_wrdata == 32'hDEAD_BEEF && d_wait) good++;
      step();
    end
    @(negedge clk);
    chk("stall_stable", 32'(good), 6);
    chk("stall_wren_cycles", 32'(qwren), 6);
    chk("stall_dwait_release", 32'(d_wait), 0);
    chk("stall_direct_addr", 32'(fm_addr), 32'h21);
    step();
    d_wren = 0;
    drain("stall_drain");
    chk("stall_issue_cycle", 32'(iss_cyc.size() > 0 ? iss_cyc[0] : -1), 32'(n0 + 7));
    chk("stall_direct_cycle", 32'(last_d_cyc), 32'(n0 + 8));
    chk("stall_single_pop", 32'(iss_cyc.size()), 1);
    iss_cyc.delete();
    n0 = cyc;
    fm_wait = 1;
    qpush(16'd1, 8'h90, 32'h9090_9090);
    dstart(8'h82, 32'h0000_0082);
    step();
    q_push = 0;
    xc = exp_issue(n0 + 1, 1) + 3;
    while (cyc < xc - 1) step();
    fm_wait = 0;
    step();
    d_wren = 0;
    drain("prio_drain");
    chk("prio_direct_cycle", 32'(last_d_cyc), 32'(xc - 1));
    chk("prio_queue_cycle", 32'(iss_cyc.size() > 0 ? iss_cyc[0] : -1), 32'(xc + 1));
    iss_cyc.delete();
    sched_en = 0;
    m_ovf = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      qpush(16'(i), 8'(8'hA0 + i), $urandom);
      step();
    end
    q_push = 0;
    @(negedge clk);
    chk("ovf_level", 32'(q_level), 32'(qsb.size()));
    chk("ovf_full", 32'(q_full), 32'(qsb.size() == DEPTH));
    chk("ovf_flag", 32'(q_ovf), 32'(m_ovf));
    chk("ovf_busy", 32'(busy), 0);
    step();
    q_flush = 1;
    q_push = 1;
    q_addr = 8'hEE;
    step();
    q_flush = 0;
    q_push = 0;
    qsb.delete();
    m_ovf = 0;
    @(negedge clk);
    chk("flush_level", 32'(q_level), 0);
    chk("flush_ovf", 32'(q_ovf), 32'(m_ovf));
    chk("flush_full", 32'(q_full), 0);
    step();
    sched_en = 1;
    qwren = 0;
    repeat (20) step();
    chk("flush_no_wren", 32'(qwren), 0);
    chk("flush_no_issue", 32'(iss_cyc.size()), 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      dn = d_wren && !d_wait;
      step();
      q_push = 0;
      if (dn) d_wren = 0;
      else if (!d_wren && $urandom_range(0, 7) == 0) dstart(8'($urandom), $urandom);
      fm_wait = $urandom_range(0, 3) == 0;
      sched_en = $urandom_range(0, 15) != 0;
      if (qsb.size() < DEPTH - 1 && $urandom_range(0, 3) == 0)
        qpush(16'($urandom_range(0, 3)), 8'($urandom), $urandom);
    end
    @(negedge clk);
    dn = d_wren && !d_wait;
    step();
    q_push = 0;
    if (dn) d_wren = 0;
    fm_wait = 0;
    sched_en = 1;
    drain("rand_drain");
    chk("rand_qsb_empty", 32'(qsb.size()), 0);
    chk("rand_dsb_empty", 32'(dsb.size()), 0);
    n0 = cyc;
    qpush(16'd0, 8'h33, 32'h3333_3333);
    step();
    q_push = 0;
    step();
    fm_wait = 1;
    @(negedge clk);
    chk("rstmid_in_issue", 32'(fm_wren && d_wait), 1);
    #2 reset = 1;
    #1;
    chk("rstmid_wren_drop", 32'(fm_wren), 0);
    chk("rstmid_level", 32'(q_level), 0);
    chk("rstmid_busy", 32'(busy), 0);
    qsb.delete();
    step();
    reset = 0;
    fm_wait = 0;
    @(negedge clk);
    chk("rstmid_level_after", 32'(q_level), 0);
    chk("rstmid_busy_after", 32'(busy), 0);
    chk("rstmid_wren_after", 32'(fm_wren), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
